mult_result_acc: RTL and testbench

//   Downstream consumer of the multiplier. Captures each product (ab) on the rising edge
//   of the multiplier's done, buffers it in a small FIFO and sums COUNT consecutive

---
 rtl/mult_result_acc.sv | 224 ++++++++++++++++++++++
 tb/tb_mult_result_acc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_result_acc
//
// Downstream consumer of a multiplier. Each rising edge of done_i captures the
// product ab_i into a small FIFO. A two-state FSM drains the FIFO one entry per
// cycle into an accumulator; every COUNT products form one result that is
// offered on a valid/ready port and held stable until accepted. hold_o tells
// the upstream request driver to stop issuing requests when the FIFO is close
// to full.
//
// Optional feature macro: MRA_DROP_CNT_EN
//   defined   -> drop_cnt port and an 8-bit saturating dropped-product counter
//   undefined -> no drop_cnt port; products arriving at a full FIFO are lost
//                silently
//
// Parameters
//   WIDTH      multiplier operand width (product is 2*WIDTH bits)
//   COUNT      products summed per result (>= 1)
//   FIFO_DEPTH product buffer entries (power of 2, >= 2)
//   ACCW       accumulator/result width, wide enough that COUNT products
//              never overflow
//
// Ports
//   clk        single clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   done_i     multiplier done; a product is captured on its rising edge
//   ab_i       multiplier product, sampled in the capture cycle
//   hold_o     1 when the FIFO has at most one free entry
//   sum_o      accumulated result
//   sum_valid  sum_o is valid
//   sum_ready  consumer accepts sum_o when sum_valid && sum_ready
//   drop_cnt   saturating count of dropped products (MRA_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module mult_result_acc #(
   parameter  int WIDTH      = 5,
   parameter  int COUNT      = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int ACCW       = 2*WIDTH + $clog2(COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              done_i,
   input  logic [2*WIDTH-1:0] ab_i,
   output logic              hold_o,
   output logic [ACCW-1:0]   sum_o,
   output logic              sum_valid,
   input  logic              sum_ready
`ifdef MRA_DROP_CNT_EN
   ,
   output logic [7:0]        drop_cnt
`endif
);

   localparam int PW = 2*WIDTH;                       // product width
   localparam int AW = $clog2(FIFO_DEPTH);            // FIFO pointer width
   localparam int CW = AW + 1;                        // occupancy width (0..DEPTH)
   localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

   typedef enum logic {
      S_ACC = 1'b0,   // draining the FIFO into the accumulator
      S_OUT = 1'b1    // presenting a finished result
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e          state_q,     state_d;
   logic            done_q;
   logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0]   occ_q,       occ_d;
   logic [ACCW-1:0] acc_q,       acc_d;
   logic [IW-1:0]   idx_q,       idx_d;
   logic [ACCW-1:0] sum_q,       sum_d;
   logic            sum_valid_q, sum_valid_d;
   logic            hold_q,      hold_d;

   logic [PW-1:0]   mem [FIFO_DEPTH];

   // ---------------------------------------------------------------------------
   // Capture / FIFO control
   // ---------------------------------------------------------------------------
   logic            push;       // rising edge of done_i
   logic            pop;        // FSM takes the head entry this cycle
   logic            push_ok;    // capture actually written into the FIFO
   logic            fifo_full;
   logic            fifo_empty;
   logic [ACCW-1:0] acc_sum;    // accumulator plus the popped entry
   logic            last_pop;   // this pop completes a group of COUNT

   assign push       = done_i && !done_q;
   assign fifo_full  = (occ_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (occ_q == '0);
   assign pop        = (state_q == S_ACC) && !fifo_empty;
   // A full FIFO still accepts a capture when the head leaves in the same cycle.
   assign push_ok    = push && (!fifo_full || pop);
   assign acc_sum    = acc_q + ACCW'(mem[rd_ptr_q]);
   assign last_pop   = pop && (idx_q == IW'(COUNT - 1));

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path through
      // this block can leave a value unassigned and infer a latch.
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      sum_valid_d = sum_valid_q;

      // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH for free.
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push_ok, pop})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase

      unique case (state_q)
         S_ACC: begin
            if (pop) begin
               if (last_pop) begin
                  sum_d       = acc_sum;
                  sum_valid_d = 1'b1;
                  acc_d       = '0;
                  idx_d       = '0;
                  state_d     = S_OUT;
               end else begin
                  acc_d = acc_sum;
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_OUT: begin
            // Result held stable until the consumer takes it; captures keep
            // filling the FIFO meanwhile.
            if (sum_valid_q && sum_ready) begin
               sum_valid_d = 1'b0;
               state_d     = S_ACC;
            end
         end
         default: state_d = S_ACC;
      endcase

      // Registered hold: looks at occupancy after this cycle's push/pop.
      hold_d = (occ_d >= CW'(FIFO_DEPTH - 1));
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ACC;
         done_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_i;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
         hold_q      <= hold_d;
      end
   end

   // NOTE: the product storage is deliberately not reset; an entry is only
   // ever read after it has been written, because occupancy is reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= ab_i;
      end
   end

`ifdef MRA_DROP_CNT_EN
   // Dropped product: capture while full with no pop to make room.
   logic       drop;
   logic [7:0] drop_cnt_q;

   assign drop = push && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign hold_o    = hold_q;
   assign sum_o     = sum_q;
   assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_mult_result_acc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mult_result_acc
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model tracks buffered products, the partial group and the offered result;
// finished sums go into a scoreboard queue which a negedge monitor pops and
// compares whenever the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_mult_result_acc;

   localparam int WIDTH = 5;
   localparam int COUNT = 4;
   localparam int DEPTH = 4;
   localparam int ACCW  = 2*WIDTH + $clog2(COUNT);

   logic               clk = 1'b0;
   logic               rst;
   logic               done_i;
   logic [2*WIDTH-1:0] ab_i;
   logic               hold_o;
   logic [ACCW-1:0]    sum_o;
   logic               sum_valid;
   logic               sum_ready;
`ifdef MRA_DROP_CNT_EN
   logic [7:0]         drop_cnt;
`endif

   mult_result_acc #(
      .WIDTH      (WIDTH),
      .COUNT      (COUNT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .done_i    (done_i),
      .ab_i      (ab_i),
      .hold_o    (hold_o),
      .sum_o     (sum_o),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready)
`ifdef MRA_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: products wait in a bounded queue; while no result is on
   // offer one product per cycle joins the current group; a full group becomes
   // the offered result and stays offered until accepted.
   // ---------------------------------------------------------------------------
   int unsigned buf_q[$];
   int unsigned grp_q[$];
   int unsigned exp_q[$];
   bit          m_valid;
   bit          m_done_prev;
   bit          m_hold;
   int          m_drops;

   always @(posedge clk) begin
      bit          cap;
      bit          hs;
      bit          take;
      int unsigned s;
      if (rst) begin
         buf_q.delete();
         grp_q.delete();
         exp_q.delete();
         m_valid     = 1'b0;
         m_done_prev = 1'b0;
         m_hold      = 1'b0;
         m_drops     = 0;
      end else begin
         cap         = done_i && !m_done_prev;
         m_done_prev = done_i;
         hs          = m_valid && sum_ready;
         take        = !m_valid && (buf_q.size() > 0);
         if (take) begin
            grp_q.push_back(buf_q.pop_front());
            if (grp_q.size() == COUNT) begin
               s = 0;
               foreach (grp_q[i]) s += grp_q[i];
               exp_q.push_back(s);
               grp_q.delete();
               m_valid = 1'b1;
            end
         end
         if (hs) m_valid = 1'b0;
         if (cap) begin
            if (buf_q.size() < DEPTH) buf_q.push_back(int'(ab_i));
            else if (m_drops < 255) m_drops++;
         end
         m_hold = (buf_q.size() >= DEPTH - 1);
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: compares on the falling edge, away from the sampling edge.
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (mon_en) begin
         check("sum_valid", 32'(sum_valid), 32'(m_valid));
         check("hold_o", 32'(hold_o), 32'(m_hold));
`ifdef MRA_DROP_CNT_EN
         check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
         if (sum_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sum_o: got %0d with no result expected (t=%0t)", sum_o, $time);
            end else begin
               check("sum_o", 32'(sum_o), exp_q[0]);
               if (sum_ready && !rst) void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int unsigned v);
      done_i = 1'b1;
      ab_i   = (2*WIDTH)'(v);
      tick();
      done_i = 1'b0;
      ab_i   = (2*WIDTH)'($urandom);
      tick();
   endtask

   task automatic wait_valid(input string name, input int unsigned exp);
      int k = 0;
      while (!sum_valid && k < 40) begin
         tick();
         k++;
      end
      if (!sum_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: sum_valid not seen within 40 cycles, expected sum %0d", name, exp);
      end else begin
         check(name, 32'(sum_o), exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      done_i    = 1'b0;
      ab_i      = '0;
      sum_ready = 1'b1;

      // 1: reset
      tick();
      tick();
      check("reset_sum_valid", 32'(sum_valid), 32'd0);
      check("reset_sum_o", 32'(sum_o), 32'd0);
      check("reset_hold_o", 32'(hold_o), 32'd0);
      mon_en = 1'b1;
      rst    = 1'b0;
      tick();

      // 2: basic group of four
      pulse(3);
      pulse(10);
      pulse(100);
      pulse(961);
      wait_valid("basic_sum", 1074);
      tick();
      check("basic_one_cycle", 32'(sum_valid), 32'd0);

      // 3: done held high five cycles -> a single capture of 7
      done_i = 1'b1;
      ab_i   = 10'd7;
      repeat (5) tick();
      done_i = 1'b0;
      repeat (3) tick();
      check("long_done_no_result", 32'(sum_valid), 32'd0);
      pulse(1);
      pulse(1);
      pulse(1);
      wait_valid("long_done_sum", 10);
      tick();

      // 4: backpressure
      sum_ready = 1'b0;
      repeat (4) pulse(961);
      repeat (4) pulse(1);
      check("bp_valid_held", 32'(sum_valid), 32'd1);
      check("bp_sum_held", 32'(sum_o), 32'd3844);
      check("bp_hold_o", 32'(hold_o), 32'd1);
      sum_ready = 1'b1;
      tick();
      wait_valid("bp_second_sum", 4);
      tick();

      // 5: overflow while the result is held
      sum_ready = 1'b0;
      for (int i = 1; i <= 9; i++) pulse(i);
      check("ovf_sum_held", 32'(sum_o), 32'd10);
`ifdef MRA_DROP_CNT_EN
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      sum_ready = 1'b1;
      tick();
      wait_valid("ovf_second_sum", 26);
      tick();

      // 6: reset mid-accumulation
      pulse(50);
      pulse(60);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", 32'(sum_valid), 32'd0);
      pulse(1);
      pulse(2);
      pulse(3);
      pulse(4);
      wait_valid("midrst_sum", 10);
      tick();

      // Randomized run, including occasional resets and backpressure
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 399) == 0);
         done_i    = ($urandom_range(0, 2) == 0);
         ab_i      = (2*WIDTH)'($urandom);
         sum_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Drain whatever is on offer
      rst       = 1'b0;
      done_i    = 1'b0;
      sum_ready = 1'b1;
      repeat (30) tick();
      check("drained", 32'(exp_q.size()), 32'd0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
